// File: rtl/kronos_wb_arbiter_pkg.sv
// Shared types and constants for the Kronos write-back arbiter and scoreboard.
package kronos_wb_arbiter_pkg;

  // Write-back producers. The enum value doubles as the request/grant bit index.
  typedef enum logic [1:0] {
    WB_EXE = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_src_t;

  localparam int WB_NSRC      = 3;
  localparam int STARVE_CNT_W = 4;
  localparam int REG_AW       = 5;
  localparam int XLEN         = 32;

  // Fixed priority pick: lowest set bit wins, so exe > lsu > csr.
  function automatic logic [WB_NSRC-1:0] first_one(input logic [WB_NSRC-1:0] req);
    logic [WB_NSRC-1:0] pick;
    pick = '0;
    for (int i = WB_NSRC - 1; i >= 0; i--) begin
      if (req[i]) pick = WB_NSRC'(1) << i;
    end
    return pick;
  endfunction

endpackage

// File: rtl/kronos_wb_arbiter_if.sv
// Issue, write-back and register-file write signals of the arbiter.
// The slave modport is the arbiter; master is the surrounding pipeline.
interface kronos_wb_arbiter_if;
  import kronos_wb_arbiter_pkg::*;

  logic              flush;
  logic              issue_vld;
  logic [REG_AW-1:0] issue_rs1;
  logic [REG_AW-1:0] issue_rs2;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_rs1_en;
  logic              issue_rs2_en;
  logic              issue_rd_en;
  logic              issue_ack;
  logic              stall;

  logic              exe_wb_vld;
  logic [REG_AW-1:0] exe_wb_rd;
  logic [XLEN-1:0]   exe_wb_data;
  logic              exe_wb_rdy;
  logic              lsu_wb_vld;
  logic [REG_AW-1:0] lsu_wb_rd;
  logic [XLEN-1:0]   lsu_wb_data;
  logic              lsu_wb_rdy;
  logic              csr_wb_vld;
  logic [REG_AW-1:0] csr_wb_rd;
  logic [XLEN-1:0]   csr_wb_data;
  logic              csr_wb_rdy;

  logic              regwr_en;
  logic [REG_AW-1:0] regwr_sel;
  logic [XLEN-1:0]   regwr_data;

  modport slave (
    input  flush, issue_vld, issue_rs1, issue_rs2, issue_rd,
           issue_rs1_en, issue_rs2_en, issue_rd_en,
           exe_wb_vld, exe_wb_rd, exe_wb_data,
           lsu_wb_vld, lsu_wb_rd, lsu_wb_data,
           csr_wb_vld, csr_wb_rd, csr_wb_data,
    output issue_ack, stall, exe_wb_rdy, lsu_wb_rdy, csr_wb_rdy,
           regwr_en, regwr_sel, regwr_data
  );

  modport master (
    output flush, issue_vld, issue_rs1, issue_rs2, issue_rd,
           issue_rs1_en, issue_rs2_en, issue_rd_en,
           exe_wb_vld, exe_wb_rd, exe_wb_data,
           lsu_wb_vld, lsu_wb_rd, lsu_wb_data,
           csr_wb_vld, csr_wb_rd, csr_wb_data,
    input  issue_ack, stall, exe_wb_rdy, lsu_wb_rdy, csr_wb_rdy,
           regwr_en, regwr_sel, regwr_data
  );

endinterface

// File: rtl/kronos_wb_scoreboard.sv
// Per-register pending-write scoreboard: stalls decode on RAW/WAW hazards
// against any in-flight producer, sets on issue and clears on register write.
module kronos_wb_scoreboard
  import kronos_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rstz,
  input  logic              flush,
  input  logic              issue_vld,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_rs1_en,
  input  logic              issue_rs2_en,
  input  logic              issue_rd_en,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_sel,
  output logic              issue_ack,
  output logic              stall
);

  logic [31:0] pend;
  logic [31:0] pend_nxt;

  // Hazard detect against the current scoreboard; x0 never reads as pending.
  always_comb begin
    stall = issue_vld & ((issue_rs1_en & pend[issue_rs1]) |
                         (issue_rs2_en & pend[issue_rs2]) |
                         (issue_rd_en  & pend[issue_rd]));
    issue_ack = issue_vld & ~stall & ~flush & rstz;
  end

  // Next scoreboard: clear first, then set, so a same-index set wins.
  // NOTE: every variable assigned in always_comb gets a default on entry so no latch is inferred.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_sel] = 1'b0;
    if (issue_ack && issue_rd_en && (issue_rd != '0)) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard state; reset drops every pending write.
  // NOTE: this is a 32-bit flop vector, not a memory, so clearing it on reset is cheap and required.
  always_ff @(posedge clk) begin
    if (!rstz) pend <= '0;
    else       pend <= pend_nxt;
  end

endmodule

// File: rtl/kronos_wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between the
// execute, load/store and CSR producers with aged priority, and wraps the
// pending-write scoreboard that gates issue.
module kronos_wb_arbiter
  import kronos_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rstz,
  kronos_wb_arbiter_if.slave  bus
);

  logic [WB_NSRC-1:0]      req;
  logic [WB_NSRC-1:0]      aged;
  logic [WB_NSRC-1:0]      gnt;
  logic [REG_AW-1:0]       src_rd   [WB_NSRC];
  logic [XLEN-1:0]         src_data [WB_NSRC];
  logic [STARVE_CNT_W-1:0] wait_cnt [WB_NSRC];
  logic [REG_AW-1:0]       gnt_rd;
  logic [XLEN-1:0]         gnt_data;

  assign req                = {bus.csr_wb_vld, bus.lsu_wb_vld, bus.exe_wb_vld};
  assign src_rd[WB_EXE]     = bus.exe_wb_rd;
  assign src_rd[WB_LSU]     = bus.lsu_wb_rd;
  assign src_rd[WB_CSR]     = bus.csr_wb_rd;
  assign src_data[WB_EXE]   = bus.exe_wb_data;
  assign src_data[WB_LSU]   = bus.lsu_wb_data;
  assign src_data[WB_CSR]   = bus.csr_wb_data;

  assign bus.exe_wb_rdy = gnt[WB_EXE];
  assign bus.lsu_wb_rdy = gnt[WB_LSU];
  assign bus.csr_wb_rdy = gnt[WB_CSR];

  // Arbitration: aged requesters outrank unaged ones; no grant during reset.
  always_comb begin
    for (int i = 0; i < WB_NSRC; i++) begin
      aged[i] = req[i] && (wait_cnt[i] == STARVE_CNT_W'(STARVE_LIMIT));
    end
    gnt = '0;
    if (rstz) gnt = (|aged) ? first_one(aged) : first_one(req);
  end

  // Grant mux; the grant is one-hot so at most one source is selected.
  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < WB_NSRC; i++) begin
      if (gnt[i]) begin
        gnt_rd   = src_rd[i];
        gnt_data = src_data[i];
      end
    end
  end

  // Saturating wait counters: count ungranted valid cycles, clear otherwise.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_NSRC; i++) begin
      if (!rstz || !req[i] || gnt[i]) wait_cnt[i] <= '0;
      else if (wait_cnt[i] != '1)     wait_cnt[i] <= wait_cnt[i] + 1'b1;
    end
  end

  // Output register: one write per granted transfer, x0 writes are dropped.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      bus.regwr_en   <= 1'b0;
      bus.regwr_sel  <= '0;
      bus.regwr_data <= '0;
    end else if (|gnt) begin
      bus.regwr_en   <= (gnt_rd != '0);
      bus.regwr_sel  <= gnt_rd;
      bus.regwr_data <= gnt_data;
    end else begin
      bus.regwr_en   <= 1'b0;
    end
  end

  kronos_wb_scoreboard u_sb (
    .clk          (clk),
    .rstz         (rstz),
    .flush        (bus.flush),
    .issue_vld    (bus.issue_vld),
    .issue_rs1    (bus.issue_rs1),
    .issue_rs2    (bus.issue_rs2),
    .issue_rd     (bus.issue_rd),
    .issue_rs1_en (bus.issue_rs1_en),
    .issue_rs2_en (bus.issue_rs2_en),
    .issue_rd_en  (bus.issue_rd_en),
    .clr_en       (bus.regwr_en),
    .clr_sel      (bus.regwr_sel),
    .issue_ack    (bus.issue_ack),
    .stall        (bus.stall)
  );

endmodule

// File: tb/tb_kronos_wb_arbiter.sv
// Directed bench for kronos_wb_arbiter: reset, RAW/WAW stalls, arbitration
// order, starvation promotion, flush, x0 write-back and set-wins-over-clear.
module tb_kronos_wb_arbiter;
  import kronos_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstz;
  always #5 clk = ~clk;

  kronos_wb_arbiter_if bus ();

  kronos_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int proto_err   = 0;

  logic [2:0]  rdy3;
  logic [31:0] pend;
  assign rdy3 = {bus.csr_wb_rdy, bus.lsu_wb_rdy, bus.exe_wb_rdy};
  assign pend = dut.u_sb.pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [4:0] rs1, input logic rs1_en,
                           input logic [4:0] rs2, input logic rs2_en,
                           input logic [4:0] rd,  input logic rd_en);
    bus.issue_vld    = 1'b1;
    bus.issue_rs1    = rs1;
    bus.issue_rs1_en = rs1_en;
    bus.issue_rs2    = rs2;
    bus.issue_rs2_en = rs2_en;
    bus.issue_rd     = rd;
    bus.issue_rd_en  = rd_en;
  endtask

  task automatic idle_issue();
    bus.issue_vld    = 1'b0;
    bus.issue_rs1_en = 1'b0;
    bus.issue_rs2_en = 1'b0;
    bus.issue_rd_en  = 1'b0;
  endtask

  // Protocol monitor: a write-back to a register that is not pending.
  always @(posedge clk) begin
    if (rstz === 1'b1) begin
      if (bus.exe_wb_vld && bus.exe_wb_rdy && bus.exe_wb_rd != 0 && !pend[bus.exe_wb_rd]) proto_err++;
      if (bus.lsu_wb_vld && bus.lsu_wb_rdy && bus.lsu_wb_rd != 0 && !pend[bus.lsu_wb_rd]) proto_err++;
      if (bus.csr_wb_vld && bus.csr_wb_rdy && bus.csr_wb_rd != 0 && !pend[bus.csr_wb_rd]) proto_err++;
    end
  end

  initial begin
    // Reset with every producer and decode requesting.
    rstz = 1'b0;
    bus.flush = 1'b0;
    set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    bus.exe_wb_vld = 1'b1; bus.exe_wb_rd = 5'd0; bus.exe_wb_data = 32'h1;
    bus.lsu_wb_vld = 1'b1; bus.lsu_wb_rd = 5'd0; bus.lsu_wb_data = 32'h2;
    bus.csr_wb_vld = 1'b1; bus.csr_wb_rd = 5'd0; bus.csr_wb_data = 32'h3;
    #4;
    check("rst_rdy_comb", rdy3, 3'b000);
    check("rst_ack", bus.issue_ack, 1'b0);
    tick();
    tick();
    check("rst_regwr_en", bus.regwr_en, 1'b0);
    check("rst_regwr_sel", bus.regwr_sel, 5'd0);
    check("rst_regwr_data", bus.regwr_data, 32'h0);
    check("rst_pend", pend, 32'h0);
    check("rst_rdy", rdy3, 3'b000);

    // Release: exe first, then lsu and csr; all rd=0 so nothing is written.
    rstz = 1'b1;
    idle_issue();
    #4; check("rel_exe_first", rdy3, 3'b001);
    tick(); bus.exe_wb_vld = 1'b0;
    check("rd0_exe_no_write", bus.regwr_en, 1'b0);
    #4; check("rel_lsu_next", rdy3, 3'b010);
    tick(); bus.lsu_wb_vld = 1'b0;
    check("rd0_lsu_no_write", bus.regwr_en, 1'b0);
    check("rd0_pend", pend, 32'h0);
    #4; check("rel_csr_next", rdy3, 3'b100);
    tick(); bus.csr_wb_vld = 1'b0;
    #4; check("rel_idle", rdy3, 3'b000);

    // RAW on x5.
    tick(); set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    #4; check("raw_prod_ack", bus.issue_ack, 1'b1);
    check("raw_prod_stall", bus.stall, 1'b0);
    tick(); set_issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.exe_wb_vld = 1'b1; bus.exe_wb_rd = 5'd5; bus.exe_wb_data = 32'hDEAD_0005;
    #4; check("raw_stall_t1", bus.stall, 1'b1);
    check("raw_noack_t1", bus.issue_ack, 1'b0);
    check("raw_exe_gnt", rdy3, 3'b001);
    tick(); bus.exe_wb_vld = 1'b0;
    check("raw_wr_en", bus.regwr_en, 1'b1);
    check("raw_wr_sel", bus.regwr_sel, 5'd5);
    check("raw_wr_data", bus.regwr_data, 32'hDEAD_0005);
    #4; check("raw_stall_t1p1", bus.stall, 1'b1);
    tick();
    check("raw_idle_en", bus.regwr_en, 1'b0);
    check("raw_sel_hold", bus.regwr_sel, 5'd5);
    #4; check("raw_ack_t2", bus.issue_ack, 1'b1);
    check("raw_nostall_t2", bus.stall, 1'b0);

    // Three simultaneous producers, back-to-back writes.
    tick(); set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
    tick(); set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1);
    tick(); set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
    tick(); idle_issue();
    check("sim_pend", pend, 32'h0000_1C00);
    bus.exe_wb_vld = 1'b1; bus.exe_wb_rd = 5'd10; bus.exe_wb_data = 32'hA000_000A;
    bus.lsu_wb_vld = 1'b1; bus.lsu_wb_rd = 5'd11; bus.lsu_wb_data = 32'hB000_000B;
    bus.csr_wb_vld = 1'b1; bus.csr_wb_rd = 5'd12; bus.csr_wb_data = 32'hC000_000C;
    #4; check("sim_gnt_exe", rdy3, 3'b001);
    tick(); bus.exe_wb_vld = 1'b0;
    check("sim_wr1_en", bus.regwr_en, 1'b1);
    check("sim_wr1_sel", bus.regwr_sel, 5'd10);
    check("sim_wr1_data", bus.regwr_data, 32'hA000_000A);
    #4; check("sim_gnt_lsu", rdy3, 3'b010);
    tick(); bus.lsu_wb_vld = 1'b0;
    check("sim_wr2_sel", bus.regwr_sel, 5'd11);
    check("sim_wr2_data", bus.regwr_data, 32'hB000_000B);
    #4; check("sim_gnt_csr", rdy3, 3'b100);
    tick(); bus.csr_wb_vld = 1'b0;
    check("sim_wr3_en", bus.regwr_en, 1'b1);
    check("sim_wr3_sel", bus.regwr_sel, 5'd12);
    check("sim_wr3_data", bus.regwr_data, 32'hC000_000C);
    tick();
    check("sim_pend_clr", pend, 32'h0);
    check("sim_idle_en", bus.regwr_en, 1'b0);

    // Starvation: exe always valid, csr promoted on its 5th waiting cycle.
    set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1);
    #4; check("stv_ack", bus.issue_ack, 1'b1);
    tick(); idle_issue();
    bus.exe_wb_vld = 1'b1; bus.exe_wb_rd = 5'd0;  bus.exe_wb_data = 32'h0;
    bus.csr_wb_vld = 1'b1; bus.csr_wb_rd = 5'd13; bus.csr_wb_data = 32'hC5C5_000D;
    for (int i = 0; i < 4; i++) begin
      #4; check($sformatf("stv_wait%0d", i + 1), rdy3, 3'b001);
      tick();
    end
    #4; check("stv_csr_aged", rdy3, 3'b100);
    tick(); bus.csr_wb_vld = 1'b0;
    check("stv_wr_en", bus.regwr_en, 1'b1);
    check("stv_wr_sel", bus.regwr_sel, 5'd13);
    check("stv_wr_data", bus.regwr_data, 32'hC5C5_000D);
    #4; check("stv_exe_resume", rdy3, 3'b001);
    tick(); bus.exe_wb_vld = 1'b0;

    // Flush kills the issue but not the earlier pending x3.
    set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    #4; check("fl_pre_ack", bus.issue_ack, 1'b1);
    tick(); set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    bus.flush = 1'b1;
    #4; check("fl_noack", bus.issue_ack, 1'b0);
    tick(); bus.flush = 1'b0; idle_issue();
    check("fl_pend", pend, 32'h0000_0008);
    bus.exe_wb_vld = 1'b1; bus.exe_wb_rd = 5'd3; bus.exe_wb_data = 32'hE000_0003;
    #4; check("fl_wb_gnt", rdy3, 3'b001);
    tick(); bus.exe_wb_vld = 1'b0;
    check("fl_wr_en", bus.regwr_en, 1'b1);
    check("fl_wr_sel", bus.regwr_sel, 5'd3);
    tick();
    check("fl_pend_clr", pend, 32'h0);

    // WAW on x9.
    set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    #4; check("waw_prod_ack", bus.issue_ack, 1'b1);
    tick(); set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    check("waw_pend", pend, 32'h0000_0200);
    bus.lsu_wb_vld = 1'b1; bus.lsu_wb_rd = 5'd9; bus.lsu_wb_data = 32'hF000_0009;
    #4; check("waw_stall", bus.stall, 1'b1);
    check("waw_noack", bus.issue_ack, 1'b0);
    check("waw_lsu_gnt", rdy3, 3'b010);
    tick(); bus.lsu_wb_vld = 1'b0; idle_issue();
    check("waw_wr_sel", bus.regwr_sel, 5'd9);
    check("waw_wr_en", bus.regwr_en, 1'b1);
    tick();
    check("waw_pend_clr", pend, 32'h0);

    // Write to a non-pending x20, then issue rd=20 while the write lands.
    bus.lsu_wb_vld = 1'b1; bus.lsu_wb_rd = 5'd20; bus.lsu_wb_data = 32'h6000_0014;
    #4; check("np_lsu_gnt", rdy3, 3'b010);
    tick(); bus.lsu_wb_vld = 1'b0;
    check("np_wr_en", bus.regwr_en, 1'b1);
    check("np_wr_sel", bus.regwr_sel, 5'd20);
    set_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1);
    #4; check("sw_ack", bus.issue_ack, 1'b1);
    check("sw_nostall", bus.stall, 1'b0);
    tick(); idle_issue();
    check("sw_set_wins", pend, 32'h0010_0000);
    bus.csr_wb_vld = 1'b1; bus.csr_wb_rd = 5'd20; bus.csr_wb_data = 32'h7000_0014;
    #4; check("sw_csr_gnt", rdy3, 3'b100);
    tick(); bus.csr_wb_vld = 1'b0;
    check("sw_wr_data", bus.regwr_data, 32'h7000_0014);
    tick();
    check("sw_pend_clr", pend, 32'h0);
    check("proto_err_count", proto_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
